// File: rtl/uart_tx_mmio_if.sv
// Core data-port bus as seen by the memory-mapped UART transmitter.
interface uart_tx_mmio_if;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;

    modport master (output d_addr, d_we, d_wr_data, input d_rd_data);
    modport slave  (input d_addr, d_we, d_wr_data, output d_rd_data);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, STATUS register, registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLoad  = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
`else
    localparam logic ParityEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic       hit, bus_rd, wr_txdata, wr_status;
    logic [1:0] offset;
    logic       unused_bits;

    assign hit       = bus.d_addr[31:4] == BASE_ADDR[31:4];
    assign offset    = bus.d_addr[3:2];
    assign bus_rd    = bus.d_we == 4'b0000;
    assign wr_txdata = hit && offset == 2'd0 && bus.d_we[0];
    assign wr_status = hit && offset == 2'd1 && bus.d_we[0];
    assign unused_bits = ^{bus.d_addr[1:0], bus.d_wr_data[31:8]};

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            full, empty, push, pop, ovf_q;

    // Full/empty come from pre-edge state, so a push while full drops even if a pop coincides.
    assign full  = count_q == DepthCnt;
    assign empty = count_q == '0;
    assign push  = wr_txdata && !full;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.d_wr_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (wr_txdata && full)                   ovf_q <= 1'b1;
            else if (wr_status && bus.d_wr_data[3])  ovf_q <= 1'b0;
        end
    end

    state_e          state_q, state_d;
    logic [DivW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d, bit_end;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    assign bit_end = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        if (state_q != StIdle) cnt_d = bit_end ? DivLoad : cnt_q - 1'b1;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    cnt_d   = DivLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (idx_q == 3'd7) state_d = StParity;
`else
                    if (idx_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                tx_d = parity_q;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = StStart;
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     parity_q <= 1'b0;
        else if (pop) parity_q <= ^mem_q[rptr_q];
    end
`endif

    assign tx = tx_q;

    logic [31:0] status, count_ext, rd_q;

    assign count_ext = 32'(count_q);
    assign status = {16'h0, count_ext[7:0], 3'b000, ParityEn, ovf_q, state_q != StIdle,
                     empty, full};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= (hit && bus_rd && offset == 2'd1) ? status : 32'h0;
    end

    assign bus.d_rd_data = rd_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio at CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;
    localparam int Div   = 4;
    localparam int Depth = 4;
`ifdef UART_TX_PARITY_EN
    localparam int Fb = 11;
    localparam logic [31:0] Par = 32'h10;
`else
    localparam int Fb = 10;
    localparam logic [31:0] Par = 32'h0;
`endif
    localparam int Fl = Fb * Div;
    localparam int Tail = 16;
    localparam logic [31:0] Base = 32'h1000_0000;
    localparam logic [31:0] Txd  = Base;
    localparam logic [31:0] Sts  = Base + 32'h4;
    localparam logic [31:0] Rsv  = Base + 32'h8;

    logic clk;
    logic rst;
    logic tx;
    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR (Base),
        .CLK_DIV   (Div),
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Records tx once per cycle from the first low sample after arming.
    logic wave [512];
    int   rec_idx;
    logic rec_on;
    logic rec_arm = 1'b0;

    always @(negedge clk) begin
        if (!rec_arm) begin
            rec_on  <= 1'b0;
            rec_idx <= 0;
        end else if (rec_on || tx == 1'b0) begin
            rec_on <= 1'b1;
            if (rec_idx < 512) wave[rec_idx] <= tx;
            rec_idx <= rec_idx + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] we);
        bus.d_addr    = addr;
        bus.d_we      = we;
        bus.d_wr_data = data;
        @(negedge clk);
        bus.d_addr = 32'h0;
        bus.d_we   = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.d_addr = addr;
        bus.d_we   = 4'h0;
        @(negedge clk);
        data = bus.d_rd_data;
        bus.d_addr = 32'h0;
    endtask

    task automatic wait_fall(output int lat);
        lat = 0;
        while (tx !== 1'b0 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_rec(input int need);
        int t = 0;
        while (rec_idx < need && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (rec_idx < need) check_eq("rec_timeout", 64'(rec_idx), 64'(need));
    endtask

    function automatic logic [Fb-1:0] frame_bits(input logic [7:0] b);
        logic [Fb-1:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[Fb-1] = 1'b1;
        return f;
    endfunction

    function automatic logic [63:0] frame_wave(input logic [7:0] b);
        logic [63:0]   r = '0;
        logic [Fb-1:0] f = frame_bits(b);
        for (int j = 0; j < Fb; j++)
            for (int c = 0; c < Div; c++) r[j*Div+c] = f[j];
        return r;
    endfunction

    function automatic logic [63:0] wave_slice(input int start);
        logic [63:0] r = '0;
        for (int i = 0; i < Fl; i++) r[i] = wave[start+i];
        return r;
    endfunction

    function automatic int ones(input int start, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (wave[start+i] === 1'b1) c++;
        return c;
    endfunction

    task automatic stop_rec();
        rec_arm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [7:0]  single [2] = '{8'h55, 8'h07};
    logic [7:0]  burst  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int          lat;
    int          highs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_we      = 4'h0;
        bus.d_wr_data = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 64'(tx), 64'(1'b1));
        check_eq("rst_rd", 64'(bus.d_rd_data), 64'h0);
        rst = 1'b1;
        @(negedge clk);
        bus_read(Sts, rd);
        check_eq("rst_status", 64'(rd), 64'(32'h2 | Par));

        // Upper-lane-only TXDATA write and an out-of-window write must both be ignored.
        bus_write(Txd, 32'hFF, 4'b0010);
        bus_write(Base + 32'h10, 32'h41, 4'hF);
        repeat (4) @(negedge clk);
        bus_read(Sts, rd);
        check_eq("ignored_wr", 64'(rd), 64'(32'h2 | Par));

        foreach (single[k]) begin
            rec_arm = 1'b1;
            bus_write(Txd, 32'(single[k]), 4'hF);
            wait_fall(lat);
            check_eq("start_lat", 64'(lat), 64'd2);
            wait_rec(Fl + Tail);
            check_eq($sformatf("frame_%02h", single[k]), wave_slice(0), frame_wave(single[k]));
            check_eq("frame_idle", 64'(ones(Fl, Tail)), 64'(Tail));
            stop_rec();
        end

        rec_arm = 1'b1;
        bus_write(Txd, 32'hA5, 4'hF);
        bus_write(Txd, 32'h3C, 4'hF);
        bus_read(Sts, rd);
        check_eq("b2b_busy1", 64'(rd), 64'(32'h0104 | Par));
        repeat (55) @(negedge clk);
        bus_read(Sts, rd);
        check_eq("b2b_busy2", 64'(rd), 64'(32'h0006 | Par));
        wait_rec(2 * Fl + Tail);
        check_eq("b2b_frame0", wave_slice(0), frame_wave(8'hA5));
        check_eq("b2b_frame1", wave_slice(Fl), frame_wave(8'h3C));
        check_eq("b2b_idle", 64'(ones(2 * Fl, Tail)), 64'(Tail));
        bus_read(Sts, rd);
        check_eq("b2b_done", 64'(rd), 64'(32'h0002 | Par));
        stop_rec();

        rec_arm = 1'b1;
        foreach (burst[k]) bus_write(Txd, 32'(burst[k]), 4'hF);
        bus_read(Sts, rd);
        check_eq("ovf_status", 64'(rd), 64'(32'h040D | Par));
        bus_read(Txd, rd);
        check_eq("txdata_rd", 64'(rd), 64'h0);
        bus_read(Rsv, rd);
        check_eq("rsv_rd", 64'(rd), 64'h0);
        bus_read(Base + 32'h14, rd);
        check_eq("miss_rd", 64'(rd), 64'h0);
        bus_write(Sts, 32'h8, 4'hF);
        check_eq("wr_cycle_rd", 64'(bus.d_rd_data), 64'h0);
        bus_read(Sts, rd);
        check_eq("ovf_clr", 64'(rd), 64'(32'h0405 | Par));
        wait_rec(5 * Fl + Tail);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("ovf_frame%0d", k), wave_slice(k * Fl), frame_wave(burst[k]));
        check_eq("ovf_idle", 64'(ones(5 * Fl, Tail)), 64'(Tail));
        bus_read(Sts, rd);
        check_eq("ovf_done", 64'(rd), 64'(32'h0002 | Par));
        stop_rec();

        // Reset in the middle of data bit 3 with a second byte still queued.
        bus_write(Txd, 32'h00, 4'hF);
        bus_write(Txd, 32'h00, 4'hF);
        wait_fall(lat);
        repeat (4 * Div + 1) @(negedge clk);
        check_eq("pre_rst_tx", 64'(tx), 64'(1'b0));
        #2 rst = 1'b0;
        #1 check_eq("async_rst_tx", 64'(tx), 64'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_read(Sts, rd);
        check_eq("post_rst_status", 64'(rd), 64'(32'h0002 | Par));
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx === 1'b1) highs++;
        end
        check_eq("post_rst_idle", 64'(highs), 64'd80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
